cory_dupn: RTL and testbench

Parametrised K-way stream duplicator (eager fork) with per-transaction destination mask and optional per-output queueing. One input valid/ready stream is copied to any subset of K output streams. Each output completes independently; the input is acknowledged only once every selected output has taken its copy. It sits wherever one producer feeds several independent consumers and replaces fixed-fanout duplicator trees.

---
 rtl/cory_dupn_pkg.sv | 32 +++
 rtl/cory_dupn_q.sv | 76 +++++++
 rtl/cory_dupn.sv | 120 ++++++++++++
 tb/tb_cory_dupn.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/cory_dupn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cory_dupn_pkg
//  Description : Shared helpers for the cory_dupn K-way stream duplicator.
//                - clog2         : ceiling log2 for counter and pointer widths.
//                - dupn_params_ok: legal-parameter check (K in 2..32, Q >= 0).
//  Revision    : 1.0  initial release
// ============================================================================
package cory_dupn_pkg;

    // Ceiling log2. clog2(1) = 0, clog2(2) = 1, clog2(3) = 2.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        for (int i = 0; i < 32; i++) begin
            if (rem > 0) begin
                result = result + 1;
                rem    = rem >> 1;
            end
        end
        return result;
    endfunction

    // K must lie in 2..32 and the queue depth cannot be negative.
    function automatic bit dupn_params_ok(input int k, input int q);
        return (k >= 2) && (k <= 32) && (q >= 0);
    endfunction

endpackage : cory_dupn_pkg
`default_nettype wire

// File: rtl/cory_dupn_q.sv
`default_nettype none
// ============================================================================
//  Module      : cory_dupn_q
//  Description : Single-channel N-bit FIFO of depth Q (Q >= 1) with
//                valid/ready on both sides. One output channel of cory_dupn.
//  Ports       : clk, reset_n      clock, asynchronous active-low reset
//                in_v/in_d/in_r    write side; in_r = not full
//                out_v/out_d/out_r read side; out_v = not empty
//  Revision    : 1.0  initial release
// ============================================================================
module cory_dupn_q
    import cory_dupn_pkg::*;
#(
    parameter int N = 16,
    parameter int Q = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_v,
    input  logic [N-1:0] in_d,
    output logic         in_r,
    output logic         out_v,
    output logic [N-1:0] out_d,
    input  logic         out_r
);

    localparam int CW = clog2(Q + 1);
    // A one-entry queue still needs a 1-bit pointer; it simply never leaves 0.
    localparam int PW = (Q > 1) ? clog2(Q) : 1;

    logic [N-1:0]  mem [Q];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;

    // Fullness is taken from the registered count only, so a pop at full does
    // not open a slot for a push in the same cycle. This keeps in_r (and thus
    // the duplicator's input ready) independent of the downstream ready.
    assign in_r  = (count != CW'(Q));
    assign out_v = (count != '0);
    assign out_d = mem[rd_ptr];

    assign push = in_v & in_r;
    assign pop  = out_v & out_r;

    // Storage carries no reset; validity is tracked entirely by count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PW'(Q - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(Q - 1)) ? '0 : rd_ptr + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule : cory_dupn_q
`default_nettype wire

// File: rtl/cory_dupn.sv
`default_nettype none
// ============================================================================
//  Module      : cory_dupn
//  Description : K-way eager-fork stream duplicator with per-transaction
//                destination mask and optional per-output queueing.
//                The input transaction retires only once every selected
//                output has taken its copy; each output completes on its own.
//  Ports       : clk, reset_n   clock, asynchronous active-low reset
//                i_a_v/i_a_d    input valid / data (N bits)
//                i_a_m          destination mask (K bits)
//                o_a_r          input ready (retire on i_a_v & o_a_r)
//                o_z_v/o_z_d    per-output valid / data (channel k at [k*N +: N])
//                i_z_r          per-output ready
//                o_pend         selected outputs not yet served
//  Revision    : 1.0  initial release
// ============================================================================
module cory_dupn
    import cory_dupn_pkg::*;
#(
    parameter int N = 16,
    parameter int K = 8,
    parameter int Q = 0
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           i_a_v,
    input  logic [N-1:0]   i_a_d,
    input  logic [K-1:0]   i_a_m,
    output logic           o_a_r,
    output logic [K-1:0]   o_z_v,
    output logic [K*N-1:0] o_z_d,
    input  logic [K-1:0]   i_z_r,
    output logic [K-1:0]   o_pend
);

    generate
        if (!dupn_params_ok(K, Q)) begin : g_param_check
            $error("cory_dupn: K must be in 2..32 and Q must be >= 0");
        end
    endgenerate

    logic [K-1:0] done;   // output k already holds the current transaction
    logic [K-1:0] acc;    // output k can take a copy this cycle
    logic [K-1:0] need;   // output k still owes a copy of the current transaction
    logic         retire;

    // need is also gated by reset_n so that outputs and o_pend drop at once
    // when reset asserts mid-transaction, not just at the next clock.
    assign need   = {K{i_a_v & reset_n}} & i_a_m & ~done;
    assign o_pend = need;

    // Every selected output is either already served or serviceable now.
    // An all-zero mask therefore yields ready and the transaction is dropped.
    assign o_a_r  = &(~i_a_m | done | acc);
    assign retire = i_a_v & o_a_r;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done <= '0;
        end else if (retire) begin
            done <= '0;
        end else begin
            done <= done | (need & acc);
        end
    end

    generate
        if (Q == 0) begin : g_passthru
            assign acc   = i_z_r;
            assign o_z_v = need;
            for (genvar k = 0; k < K; k++) begin : g_data
                assign o_z_d[k*N +: N] = i_a_d;
            end
        end else begin : g_queued
            for (genvar k = 0; k < K; k++) begin : g_ch
                cory_dupn_q #(
                    .N (N),
                    .Q (Q)
                ) u_q (
                    .clk     (clk),
                    .reset_n (reset_n),
                    .in_v    (need[k]),
                    .in_d    (i_a_d),
                    .in_r    (acc[k]),
                    .out_v   (o_z_v[k]),
                    .out_d   (o_z_d[k*N +: N]),
                    .out_r   (i_z_r[k])
                );
            end
        end
    endgenerate

`ifdef CORY_MON
    // Simulation monitor: upstream stability while stalled, and no output
    // being served twice within one transaction.
    logic         mon_stalled;
    logic [N-1:0] mon_d;
    logic [K-1:0] mon_m;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mon_stalled <= 1'b0;
            mon_d       <= '0;
            mon_m       <= '0;
        end else begin
            mon_stalled <= i_a_v & ~o_a_r;
            mon_d       <= i_a_d;
            mon_m       <= i_a_m;
            if (mon_stalled && i_a_v && ((i_a_d != mon_d) || (i_a_m != mon_m))) begin
                $error("cory_dupn: i_a_d/i_a_m changed while stalled");
            end
            if (|(need & acc & done)) begin
                $error("cory_dupn: duplicate delivery to an output");
            end
        end
    end
`endif

endmodule : cory_dupn
`default_nettype wire

// File: tb/tb_cory_dupn.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cory_dupn
//  Description : Self-checking bench for cory_dupn. Two instances, K=4 N=8:
//                u_dut0 with Q=0 (pass-through), u_dut1 with Q=2 (queued).
//                Per-channel expected-data queues are filled when a
//                transaction is presented and drained by a negedge monitor
//                on every output handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cory_dupn;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;

    logic        a_v0, a_r0;
    logic [7:0]  a_d0;
    logic [3:0]  a_m0, z_r0, z_v0, pend0;
    logic [31:0] z_d0;

    logic        a_v1, a_r1;
    logic [7:0]  a_d1;
    logic [3:0]  a_m1, z_r1, z_v1, pend1;
    logic [31:0] z_d1;

    cory_dupn #(.N(8), .K(4), .Q(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n),
        .i_a_v(a_v0), .i_a_d(a_d0), .i_a_m(a_m0), .o_a_r(a_r0),
        .o_z_v(z_v0), .o_z_d(z_d0), .i_z_r(z_r0), .o_pend(pend0)
    );

    cory_dupn #(.N(8), .K(4), .Q(2)) u_dut1 (
        .clk(clk), .reset_n(reset_n),
        .i_a_v(a_v1), .i_a_d(a_d1), .i_a_m(a_m1), .o_a_r(a_r1),
        .o_z_v(z_v1), .o_z_d(z_d1), .i_z_r(z_r1), .o_pend(pend1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp0 [4][$];
    logic [7:0] exp1 [4][$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, got, want);
        end
    endtask

    task automatic exp_push0(input logic [7:0] d, input logic [3:0] m);
        for (int k = 0; k < 4; k++) if (m[k]) exp0[k].push_back(d);
    endtask

    task automatic exp_push1(input logic [7:0] d, input logic [3:0] m);
        for (int k = 0; k < 4; k++) if (m[k]) exp1[k].push_back(d);
    endtask

    // Called just after a negedge; waits (bounded) for the queued DUT's ready.
    task automatic wait_ready1(input string tag);
        int n;
        n = 0;
        while (!a_r1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(a_r1), 32'd1);
    endtask

    // Scoreboard: every output handshake must match the oldest expected item.
    always @(negedge clk) begin
        if (reset_n) begin
            for (int k = 0; k < 4; k++) begin
                if (z_v0[k] && z_r0[k]) begin
                    if (exp0[k].size() == 0) chk($sformatf("dut0 z%0d unexpected", k), 32'(z_v0[k]), 32'd0);
                    else chk($sformatf("dut0 z%0d data", k), 32'(z_d0[k*8 +: 8]), 32'(exp0[k].pop_front()));
                end
                if (z_v1[k] && z_r1[k]) begin
                    if (exp1[k].size() == 0) chk($sformatf("dut1 z%0d unexpected", k), 32'(z_v1[k]), 32'd0);
                    else chk($sformatf("dut1 z%0d data", k), 32'(z_d1[k*8 +: 8]), 32'(exp1[k].pop_front()));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        a_v0 = 0; a_d0 = '0; a_m0 = '0; z_r0 = '0;
        a_v1 = 0; a_d1 = '0; a_m1 = '0; z_r1 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst z_v0", 32'(z_v0), 32'd0);
        chk("rst pend0", 32'(pend0), 32'd0);
        chk("rst a_r1", 32'(a_r1), 32'd1);
        chk("rst z_v1", 32'(z_v1), 32'd0);
        chk("rst pend1", 32'(pend1), 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // T1: full broadcast, all ready, single-cycle retire
        z_r0 = 4'hF; a_v0 = 1; a_d0 = 8'hA5; a_m0 = 4'hF;
        exp_push0(8'hA5, 4'hF);
        @(negedge clk);
        chk("t1 z_v0", 32'(z_v0), 32'hF);
        chk("t1 a_r0", 32'(a_r0), 32'd1);
        chk("t1 z_d0", z_d0, 32'hA5A5_A5A5);
        @(posedge clk); #1;

        // T2: output 2 stalls for cycles 0-2, ready again in cycle 3
        a_d0 = 8'h5A; z_r0 = 4'b1011;
        exp_push0(8'h5A, 4'hF);
        @(negedge clk);
        chk("t2 c0 a_r0", 32'(a_r0), 32'd0);
        chk("t2 c0 z_v0", 32'(z_v0), 32'hF);
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            if (c == 3) z_r0 = 4'hF;
            @(negedge clk);
            chk($sformatf("t2 c%0d pend0", c), 32'(pend0), 32'b0100);
            chk($sformatf("t2 c%0d z_v0", c), 32'(z_v0), 32'b0100);
            chk($sformatf("t2 c%0d a_r0", c), 32'(a_r0), 32'(c == 3));
        end
        @(posedge clk); #1;

        // T3: partial mask, then empty mask
        a_d0 = 8'h3C; a_m0 = 4'b0101;
        exp_push0(8'h3C, 4'b0101);
        @(negedge clk);
        chk("t3 z_v0", 32'(z_v0), 32'b0101);
        chk("t3 a_r0", 32'(a_r0), 32'd1);
        chk("t3 pend0", 32'(pend0), 32'b0101);
        @(posedge clk); #1;
        a_d0 = 8'h77; a_m0 = 4'b0000;
        @(negedge clk);
        chk("t3 zero-mask a_r0", 32'(a_r0), 32'd1);
        chk("t3 zero-mask z_v0", 32'(z_v0), 32'd0);
        chk("t3 zero-mask pend0", 32'(pend0), 32'd0);
        @(posedge clk); #1;
        a_v0 = 0;

        // T4: Q=2, all outputs stalled; third item must wait
        z_r1 = 4'h0; a_m1 = 4'hF; a_v1 = 1;
        for (int i = 1; i <= 3; i++) begin
            a_d1 = 8'(i);
            exp_push1(8'(i), 4'hF);
            @(negedge clk);
            chk($sformatf("t4 item%0d a_r1", i), 32'(a_r1), 32'(i < 3));
            if (i < 3) begin
                @(posedge clk); #1;
            end
        end
        chk("t4 z_v1 head", 32'(z_v1), 32'hF);
        chk("t4 z_d1 head", z_d1, 32'h0101_0101);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t4 still stalled", 32'(a_r1), 32'd0);
        @(posedge clk); #1;
        z_r1 = 4'hF;
        @(negedge clk);
        chk("t4 pop at full a_r1", 32'(a_r1), 32'd0);
        wait_ready1("t4 third accepted");
        @(posedge clk); #1;
        a_v1 = 0;
        repeat (4) @(negedge clk);
        for (int k = 0; k < 4; k++) chk($sformatf("t4 dut1 z%0d drained", k), 32'(exp1[k].size()), 32'd0);
        @(posedge clk); #1;

        // T5: z1 ready, z3 stalled; input stalls once z3 queue holds 2
        z_r1 = 4'b0010; a_m1 = 4'b1010; a_v1 = 1;
        for (int i = 0; i < 2; i++) begin
            a_d1 = 8'h10 + 8'(i);
            exp_push1(8'h10 + 8'(i), 4'b1010);
            @(negedge clk);
            chk($sformatf("t5 item%0d a_r1", i), 32'(a_r1), 32'd1);
            @(posedge clk); #1;
        end
        a_d1 = 8'h12;
        exp_push1(8'h12, 4'b1010);
        repeat (3) @(negedge clk);
        chk("t5 stall a_r1", 32'(a_r1), 32'd0);
        chk("t5 stall pend1", 32'(pend1), 32'b1000);
        chk("t5 z1 served", 32'(exp1[1].size()), 32'd0);
        @(posedge clk); #1;
        z_r1 = 4'b1010;
        @(negedge clk);
        wait_ready1("t5 release");
        @(posedge clk); #1;
        a_d1 = 8'h13;
        exp_push1(8'h13, 4'b1010);
        @(negedge clk);
        wait_ready1("t5 last item");
        @(posedge clk); #1;
        a_v1 = 0;
        repeat (5) @(negedge clk);
        for (int k = 0; k < 4; k++) chk($sformatf("t5 dut1 z%0d drained", k), 32'(exp1[k].size()), 32'd0);
        @(posedge clk); #1;

        // T6: reset mid-transaction with done = 1011, then re-present
        z_r0 = 4'b1011; a_m0 = 4'hF; a_d0 = 8'hC7; a_v0 = 1;
        exp_push0(8'hC7, 4'hF);
        @(negedge clk);
        chk("t6 pend0 before", 32'(pend0), 32'hF);
        @(posedge clk); #1;
        chk("t6 pend0 partial", 32'(pend0), 32'b0100);
        reset_n = 1'b0;
        #1;
        chk("t6 rst z_v0", 32'(z_v0), 32'd0);
        chk("t6 rst pend0", 32'(pend0), 32'd0);
        for (int k = 0; k < 4; k++) begin
            exp0[k].delete();
            exp1[k].delete();
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        z_r0 = 4'hF;
        exp_push0(8'hC7, 4'hF);
        @(negedge clk);
        chk("t6 re-present z_v0", 32'(z_v0), 32'hF);
        chk("t6 re-present a_r0", 32'(a_r0), 32'd1);
        @(posedge clk); #1;
        a_v0 = 0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) chk($sformatf("end dut0 z%0d drained", k), 32'(exp0[k].size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_cory_dupn
`default_nettype wire
